// File: rtl/ball_motion.sv
// Purpose : moving-ball centre generator; steps the ball once per FRAME_DIV frames, bouncing off the visible-area edges.
// Latency : frame_tick goes high 1 clk after the counters reach (V_VISIBLE, 0). Hcentre/Vcentre/hit update on the clk after that tick.
// Backpress: none; the block free-runs on the timing counters, and run=0 freezes the position.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   Hcounter, Vcounter   shared pixel/line counters from the timing generator
//   run                  1 = motion enabled, 0 = hold the current position
//   restart              synchronous return to the initial position and direction
//   Hcentre, Vcentre     registered ball centre
//   frame_tick           one-clk pulse at the start of vertical blanking
//   hit                  one-clk pulse on any wall reflection (a corner gives one pulse)
//   bounce_count         8-bit wrapping reflection counter (only with BALL_BOUNCE_CNT_EN)
//
// Optional feature macro: BALL_BOUNCE_CNT_EN

module ball_motion #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int RADIUS    = 16,
  parameter int H_INIT    = 320,
  parameter int V_INIT    = 240,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] Hcounter,
  input  logic [9:0] Vcounter,
  input  logic       run,
  input  logic       restart,
  output logic [9:0] Hcentre,
  output logic [9:0] Vcentre,
  output logic       frame_tick,
`ifdef BALL_BOUNCE_CNT_EN
  output logic       hit,
  output logic [7:0] bounce_count
`else
  output logic       hit
`endif
);

  // The edge comparisons use 11 bits so that pos+STEP cannot wrap.
  localparam logic [10:0] C_STEP = 11'(STEP);
  localparam logic [10:0] C_LO   = 11'(RADIUS);
  localparam logic [10:0] C_H_HI = 11'(H_VISIBLE - 1 - RADIUS);
  localparam logic [10:0] C_V_HI = 11'(V_VISIBLE - 1 - RADIUS);

  typedef enum logic {S_HOLD = 1'b0, S_MOVE = 1'b1} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       bounce;
  } axis_t;

  // One axis step. A move that would leave [lo, hi] is clamped to the edge and reports a bounce.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input logic        neg,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
    axis_t      res;
    logic [10:0] ext;
    ext        = {1'b0, pos};
    res.pos    = pos;
    res.bounce = 1'b0;
    if (!neg) begin
      if (ext + C_STEP > hi) begin
        res.pos    = hi[9:0];
        res.bounce = 1'b1;
      end else begin
        res.pos = pos + C_STEP[9:0];
      end
    end else begin
      if (ext < lo + C_STEP) begin
        res.pos    = lo[9:0];
        res.bounce = 1'b1;
      end else begin
        res.pos = pos - C_STEP[9:0];
      end
    end
    return res;
  endfunction

  logic       r_vb_now;
  logic       r_vb_prev;
  logic       w_vb_det;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_moving;
  logic [7:0] r_div_cnt;
  logic       w_div_last;
  logic       w_upd;
  logic [9:0] r_hcentre;
  logic [9:0] r_vcentre;
  logic       r_dx_neg;
  logic       r_dy_neg;
  logic       r_hit;
  axis_t      w_x;
  axis_t      w_y;

  // ---------------- vblank edge detect ----------------
  // The counters may dwell on (V_VISIBLE, 0) for several clks when the
  // pixel enable is slow, so only the rising edge of the match is used.
  assign w_vb_det = (Vcounter == 10'(V_VISIBLE)) && (Hcounter == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb_now  <= 1'b0;
      r_vb_prev <= 1'b0;
    end else begin
      r_vb_now  <= w_vb_det;
      r_vb_prev <= r_vb_now;
    end
  end

  assign frame_tick = r_vb_now & ~r_vb_prev;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HOLD;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = S_HOLD;
    end else begin
      case (r_state)
        S_HOLD:  if (run)  w_state_nxt = S_MOVE;
        S_MOVE:  if (!run) w_state_nxt = S_HOLD;
        default: w_state_nxt = S_HOLD;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_moving = 1'b0;
    case (r_state)
      S_MOVE:  w_moving = 1'b1;
      default: w_moving = 1'b0;
    endcase
  end

  // ---------------- frame divider ----------------
  // Only MOVE frames are counted, so pausing keeps the phase of the divider.
  assign w_div_last = (r_div_cnt == 8'(FRAME_DIV - 1));
  assign w_upd      = frame_tick & w_moving & w_div_last & ~restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= 8'd0;
    end else if (restart) begin
      r_div_cnt <= 8'd0;
    end else if (frame_tick && w_moving) begin
      r_div_cnt <= w_div_last ? 8'd0 : r_div_cnt + 8'd1;
    end
  end

  // ---------------- position and direction ----------------
  assign w_x = axis_step(r_hcentre, r_dx_neg, C_LO, C_H_HI);
  assign w_y = axis_step(r_vcentre, r_dy_neg, C_LO, C_V_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcentre <= 10'(H_INIT);
      r_vcentre <= 10'(V_INIT);
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
      r_hit     <= 1'b0;
    end else if (restart) begin
      r_hcentre <= 10'(H_INIT);
      r_vcentre <= 10'(V_INIT);
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
      r_hit     <= 1'b0;
    end else begin
      // A corner reflects both axes but still gives a single hit pulse.
      r_hit <= w_upd & (w_x.bounce | w_y.bounce);
      if (w_upd) begin
        r_hcentre <= w_x.pos;
        r_vcentre <= w_y.pos;
        if (w_x.bounce) r_dx_neg <= ~r_dx_neg;
        if (w_y.bounce) r_dy_neg <= ~r_dy_neg;
      end
    end
  end

  assign Hcentre = r_hcentre;
  assign Vcentre = r_vcentre;
  assign hit     = r_hit;

`ifdef BALL_BOUNCE_CNT_EN
  // ---------------- reflection counter ----------------
  logic [7:0] r_bounce_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bounce_cnt <= 8'd0;
    end else if (restart) begin
      r_bounce_cnt <= 8'd0;
    end else if (w_upd && (w_x.bounce || w_y.bounce)) begin
      r_bounce_cnt <= r_bounce_cnt + 8'd1;
    end
  end

  assign bounce_count = r_bounce_cnt;
`endif

endmodule
